mor1kx_wb_espresso: RTL and testbench
=====================================

Name: mor1kx_wb_espresso

Overview:
- Writeback stage for the espresso pipeline. It sits directly upstream of the espresso register file and drives that file's write strobe, write address and write data.
- It selects the result source: ALU, load data, SPR read data or link address.
- For multi-cycle sources (load, mfspr) it holds the write until the source acknowledges, and stalls the pipeline while it waits.
- It guarantees at most one register-file write per instruction.

Parameters:
OPTION_OPERAND_WIDTH, 32, data width of all result paths
OPTION_RF_ADDR_WIDTH, 5, GPR address width
FEATURE_R0_WRITE_SUPPRESS, 1, 1 = writes to GPR 0 never assert rf_we_o

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
insn_valid_i  in  1  execute stage presents a valid instruction this cycle
rf_wb_i  in  1  instruction writes a GPR
op_load_i  in  1  instruction is a load
op_mfspr_i  in  1  instruction is mfspr
op_jal_i  in  1  instruction is jal/jalr (writes link address)
rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  destination GPR
alu_result_i  in  OPTION_OPERAND_WIDTH  ALU result
link_addr_i  in  OPTION_OPERAND_WIDTH  link address (PC+8)
lsu_result_i  in  OPTION_OPERAND_WIDTH  load data
lsu_valid_i  in  1  load data valid
lsu_except_i  in  1  load faulted (bus error/alignment)
spr_result_i  in  OPTION_OPERAND_WIDTH  SPR read data
spr_ack_i  in  1  SPR read complete
pipeline_flush_i  in  1  exception/branch flush
rf_we_o  out  1  register-file write strobe
rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  register-file write address
result_o  out  OPTION_OPERAND_WIDTH  register-file write data
wb_stall_o  out  1  hold upstream stages
wb_busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE. rf_we_o=0, rfd_adr_o=0, result_o=0, wb_stall_o=0, wb_busy_o=0. Reset mid-WAIT aborts the wait with no write.
- States: IDLE, WAIT_LSU, WAIT_SPR. Outputs rfd_adr_o and result_o are registered. rf_we_o is a registered one-cycle pulse.
- IDLE, insn_valid_i & rf_wb_i & !op_load_i & !op_mfspr_i:
  - Next cycle: rf_we_o=1, rfd_adr_o=rfd_adr_i.
  - result_o = op_jal_i ? link_addr_i : alu_result_i.
  - Latency 1. Back-to-back instructions give back-to-back pulses.
- IDLE, insn_valid_i & op_load_i:
  - Latch rfd_adr_i and rf_wb_i into a pending register; go to WAIT_LSU.
  - If lsu_valid_i is already high in that cycle, take the data immediately: write next cycle, stay IDLE, no stall.
- WAIT_LSU:
  - wb_stall_o=1 combinationally.
  - On lsu_valid_i & !lsu_except_i: register lsu_result_i, pulse rf_we_o next cycle if pending rf_wb, go to IDLE. wb_stall_o drops in the lsu_valid_i cycle.
  - On lsu_except_i: go to IDLE, no write.
- WAIT_SPR: identical to WAIT_LSU, using spr_ack_i and spr_result_i. There is no SPR exception.
- wb_stall_o is asserted in WAIT_* except in the acknowledge cycle. It is also asserted in the IDLE cycle that launches a wait, unless the acknowledge arrives in that same cycle.
- pipeline_flush_i: forces IDLE next cycle and cancels any pending write.
  - A flush in the same cycle as lsu_valid_i or spr_ack_i wins: no write.
  - A flush in the same cycle as an IDLE single-cycle instruction suppresses its write.
- R0: with FEATURE_R0_WRITE_SUPPRESS=1, rf_we_o is never asserted for rfd=0. rfd_adr_o and result_o still update.
- insn_valid_i while in WAIT_* is a protocol violation, because upstream is stalled. Ignore it and flag it with an assertion in simulation.
- Ack inputs (lsu_valid_i, spr_ack_i) arriving in IDLE without a matching launch: ignored.
- When rf_we_o=0, result_o holds its last value. It only updates on accepted results.

Decomposition:
- Shared package/defines: state encodings WB_IDLE=2'd0, WB_WAIT_LSU=2'd1, WB_WAIT_SPR=2'd2, and the result-select encoding (ALU, LINK, LSU, SPR).
- Single module with no sub-module. The FSM and pending register are small enough to stay inline.

Test Plan:
1. ALU: insn_valid_i, rf_wb_i, rfd=5, alu=0x1234 -> next cycle rf_we_o=1, rfd_adr_o=5, result_o=0x1234; following cycle rf_we_o=0.
2. jal: op_jal_i, rfd=9, link=0x108 -> rf_we_o=1, rfd_adr_o=9, result_o=0x108 after 1 cycle.
3. Load, data 3 cycles later: rfd=3, lsu_valid_i with 0xDEADBEEF -> wb_stall_o high for 3 cycles; rf_we_o=1, result_o=0xDEADBEEF the cycle after lsu_valid_i; exactly one write.
4. Load with lsu_except_i on the acknowledge cycle -> returns IDLE, rf_we_o never 1. Separately, pipeline_flush_i coincident with spr_ack_i -> no write, state IDLE.
5. R0 suppression: ALU write to rfd=0, value 0xFFFF -> rf_we_o stays 0. Then rfd=1 back-to-back -> single pulse to address 1.
6. rst asserted during WAIT_LSU, then lsu_valid_i arrives -> all outputs 0, no write, wb_busy_o=0.

Source files
------------

// File: rtl/mor1kx_wb_espresso_pkg.sv
// -----------------------------------------------------------------------------
// mor1kx_wb_espresso_pkg
// Shared types for the espresso writeback stage.
//   wb_state_e : writeback FSM state encoding
//   res_sel_e  : which result path feeds the register-file write data
// -----------------------------------------------------------------------------
package mor1kx_wb_espresso_pkg;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_LSU = 2'd1,
        WB_WAIT_SPR = 2'd2
    } wb_state_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LINK = 2'd1,
        RES_LSU  = 2'd2,
        RES_SPR  = 2'd3
    } res_sel_e;

endpackage

// File: rtl/mor1kx_wb_espresso_if.sv
// -----------------------------------------------------------------------------
// mor1kx_wb_espresso_if
// Bundle of every signal between the execute side, the result sources and the
// writeback stage, plus the register-file write port driven by the stage.
//   master : execute/LSU/SPR side (drives instruction, results, acks, flush)
//   slave  : writeback stage (drives rf_we_o, rfd_adr_o, result_o, stall, busy)
// -----------------------------------------------------------------------------
interface mor1kx_wb_espresso_if #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
);
    logic                            insn_valid_i;
    logic                            rf_wb_i;
    logic                            op_load_i;
    logic                            op_mfspr_i;
    logic                            op_jal_i;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_i;
    logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i;
    logic [OPTION_OPERAND_WIDTH-1:0] link_addr_i;
    logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i;
    logic                            lsu_valid_i;
    logic                            lsu_except_i;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_result_i;
    logic                            spr_ack_i;
    logic                            pipeline_flush_i;

    logic                            rf_we_o;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_o;
    logic [OPTION_OPERAND_WIDTH-1:0] result_o;
    logic                            wb_stall_o;
    logic                            wb_busy_o;

    modport master (
        output insn_valid_i, rf_wb_i, op_load_i, op_mfspr_i, op_jal_i,
               rfd_adr_i, alu_result_i, link_addr_i, lsu_result_i,
               lsu_valid_i, lsu_except_i, spr_result_i, spr_ack_i,
               pipeline_flush_i,
        input  rf_we_o, rfd_adr_o, result_o, wb_stall_o, wb_busy_o
    );

    modport slave (
        input  insn_valid_i, rf_wb_i, op_load_i, op_mfspr_i, op_jal_i,
               rfd_adr_i, alu_result_i, link_addr_i, lsu_result_i,
               lsu_valid_i, lsu_except_i, spr_result_i, spr_ack_i,
               pipeline_flush_i,
        output rf_we_o, rfd_adr_o, result_o, wb_stall_o, wb_busy_o
    );

endinterface

// File: rtl/mor1kx_wb_espresso.sv
// -----------------------------------------------------------------------------
// mor1kx_wb_espresso
// Writeback stage of the espresso pipeline. Picks the result source (ALU,
// link address, load data, SPR data), waits for multi-cycle sources while
// stalling upstream, and issues at most one register-file write per
// instruction as a registered one-cycle pulse.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mor1kx_wb_espresso_if.slave (instruction/result inputs, RF write
//          port rf_we_o/rfd_adr_o/result_o, wb_stall_o, wb_busy_o)
// -----------------------------------------------------------------------------
module mor1kx_wb_espresso
    import mor1kx_wb_espresso_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_RF_ADDR_WIDTH      = 5,
    parameter bit FEATURE_R0_WRITE_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    mor1kx_wb_espresso_if.slave   bus
);

    localparam int DW = OPTION_OPERAND_WIDTH;
    localparam int AW = OPTION_RF_ADDR_WIDTH;

    // GPR 0 reads as zero, so a write there is dropped at the strobe only.
    function automatic logic r0_blocked(input logic [AW-1:0] adr);
        return FEATURE_R0_WRITE_SUPPRESS && (adr == '0);
    endfunction

    wb_state_e         r_state;
    wb_state_e         w_state_next;
    logic              r_pend_wb;
    logic              w_pend_wb_next;
    logic [AW-1:0]     r_pend_adr;
    logic [AW-1:0]     w_pend_adr_next;

    logic              r_rf_we;
    logic              w_rf_we_next;
    logic [AW-1:0]     r_rfd_adr;
    logic [AW-1:0]     w_rfd_adr_next;
    logic [DW-1:0]     r_result;
    logic [DW-1:0]     w_result_next;

    logic              w_stall;
    logic              w_accept;     // a result is committed this cycle
    logic [AW-1:0]     w_acc_adr;
    res_sel_e          w_sel;
    logic [DW-1:0]     w_sel_data;

    // -------------------------------------------------------------------------
    // Next-state / acceptance logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_next    = r_state;
        w_pend_wb_next  = r_pend_wb;
        w_pend_adr_next = r_pend_adr;
        w_stall         = 1'b0;
        w_accept        = 1'b0;
        w_acc_adr       = r_pend_adr;
        w_sel           = RES_ALU;

        unique case (r_state)
            WB_IDLE: begin
                // A flush alongside a new instruction squashes it entirely.
                if (bus.insn_valid_i && !bus.pipeline_flush_i) begin
                    w_acc_adr = bus.rfd_adr_i;
                    if (bus.op_load_i) begin
                        w_sel = RES_LSU;
                        if (bus.lsu_valid_i || bus.lsu_except_i) begin
                            // Load completes in the launch cycle: no wait.
                            w_accept = bus.rf_wb_i && bus.lsu_valid_i && !bus.lsu_except_i;
                        end else begin
                            w_state_next    = WB_WAIT_LSU;
                            w_pend_wb_next  = bus.rf_wb_i;
                            w_pend_adr_next = bus.rfd_adr_i;
                            w_stall         = 1'b1;
                        end
                    end else if (bus.op_mfspr_i) begin
                        w_sel = RES_SPR;
                        if (bus.spr_ack_i) begin
                            w_accept = bus.rf_wb_i;
                        end else begin
                            w_state_next    = WB_WAIT_SPR;
                            w_pend_wb_next  = bus.rf_wb_i;
                            w_pend_adr_next = bus.rfd_adr_i;
                            w_stall         = 1'b1;
                        end
                    end else if (bus.rf_wb_i) begin
                        w_accept = 1'b1;
                        w_sel    = bus.op_jal_i ? RES_LINK : RES_ALU;
                    end
                end
            end

            WB_WAIT_LSU: begin
                w_sel   = RES_LSU;
                w_stall = !(bus.lsu_valid_i || bus.lsu_except_i);
                if (bus.pipeline_flush_i || bus.lsu_except_i) begin
                    w_state_next   = WB_IDLE;
                    w_pend_wb_next = 1'b0;
                end else if (bus.lsu_valid_i) begin
                    w_state_next   = WB_IDLE;
                    w_pend_wb_next = 1'b0;
                    w_accept       = r_pend_wb;
                end
            end

            WB_WAIT_SPR: begin
                w_sel   = RES_SPR;
                w_stall = !bus.spr_ack_i;
                if (bus.pipeline_flush_i) begin
                    w_state_next   = WB_IDLE;
                    w_pend_wb_next = 1'b0;
                end else if (bus.spr_ack_i) begin
                    w_state_next   = WB_IDLE;
                    w_pend_wb_next = 1'b0;
                    w_accept       = r_pend_wb;
                end
            end

            default: begin
                w_state_next   = WB_IDLE;
                w_pend_wb_next = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Result mux and write-port next values
    // -------------------------------------------------------------------------
    always_comb begin
        unique case (w_sel)
            RES_ALU:  w_sel_data = bus.alu_result_i;
            RES_LINK: w_sel_data = bus.link_addr_i;
            RES_LSU:  w_sel_data = bus.lsu_result_i;
            RES_SPR:  w_sel_data = bus.spr_result_i;
            default:  w_sel_data = bus.alu_result_i;
        endcase

        // Address and data follow every accepted result (even to R0);
        // only the strobe is gated.
        w_rf_we_next   = w_accept && !r0_blocked(w_acc_adr);
        w_rfd_adr_next = w_accept ? w_acc_adr  : r_rfd_adr;
        w_result_next  = w_accept ? w_sel_data : r_result;
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            r_state    <= WB_IDLE;
            r_pend_wb  <= 1'b0;
            r_pend_adr <= '0;
            r_rf_we    <= 1'b0;
            r_rfd_adr  <= '0;
            r_result   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pend_wb  <= w_pend_wb_next;
            r_pend_adr <= w_pend_adr_next;
            r_rf_we    <= w_rf_we_next;
            r_rfd_adr  <= w_rfd_adr_next;
            r_result   <= w_result_next;
        end
    end

    assign bus.rf_we_o    = r_rf_we;
    assign bus.rfd_adr_o  = r_rfd_adr;
    assign bus.result_o   = r_result;
    assign bus.wb_stall_o = w_stall;
    assign bus.wb_busy_o  = (r_state != WB_IDLE);

    // Upstream is stalled during a wait, so a new instruction there is a
    // protocol error; the FSM ignores it.
    a_no_insn_in_wait : assert property (
        @(posedge clk) disable iff (rst)
        (r_state != WB_IDLE) |-> !bus.insn_valid_i
    );

endmodule

// File: tb/tb_mor1kx_wb_espresso.sv
// -----------------------------------------------------------------------------
// tb_mor1kx_wb_espresso
// Self-checking bench for the espresso writeback stage. Expected writes are
// queued when stimulus is driven and checked by a monitor when rf_we_o pulses.
// -----------------------------------------------------------------------------
module tb_mor1kx_wb_espresso;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   failed    = 0;
    int   n_writes  = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    mor1kx_wb_espresso_if #(.OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5)) bus ();

    mor1kx_wb_espresso #(
        .OPTION_OPERAND_WIDTH      (32),
        .OPTION_RF_ADDR_WIDTH      (5),
        .FEATURE_R0_WRITE_SUPPRESS (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.rf_we_o === 1'b1) begin
            wr_t e;
            n_writes++;
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write: got adr=%0d data=%h, required no write",
                         bus.rfd_adr_o, bus.result_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.rfd_adr_o !== e.adr || bus.result_o !== e.data) begin
                    failed++;
                    $display("FAIL write_data: got adr=%0d data=%h, required adr=%0d data=%h",
                             bus.rfd_adr_o, bus.result_o, e.adr, e.data);
                end
            end
        end
    end

    // Drive and sample 1 time unit after the falling edge, clear of both edges
    // and after the monitor has run.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.insn_valid_i     = 1'b0;
        bus.rf_wb_i          = 1'b0;
        bus.op_load_i        = 1'b0;
        bus.op_mfspr_i       = 1'b0;
        bus.op_jal_i         = 1'b0;
        bus.rfd_adr_i        = '0;
        bus.alu_result_i     = '0;
        bus.link_addr_i      = '0;
        bus.lsu_result_i     = '0;
        bus.lsu_valid_i      = 1'b0;
        bus.lsu_except_i     = 1'b0;
        bus.spr_result_i     = '0;
        bus.spr_ack_i        = 1'b0;
        bus.pipeline_flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        tests_run++; if (bus.rf_we_o !== 1'b0) begin failed++; $display("FAIL reset_we: got %b, required 0", bus.rf_we_o); end
        tests_run++; if (bus.rfd_adr_o !== 5'd0) begin failed++; $display("FAIL reset_adr: got %0d, required 0", bus.rfd_adr_o); end
        tests_run++; if (bus.result_o !== 32'd0) begin failed++; $display("FAIL reset_result: got %h, required 0", bus.result_o); end
        tests_run++; if (bus.wb_stall_o !== 1'b0) begin failed++; $display("FAIL reset_stall: got %b, required 0", bus.wb_stall_o); end
        tests_run++; if (bus.wb_busy_o !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b, required 0", bus.wb_busy_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1;
        bus.rfd_adr_i = 5'd5; bus.alu_result_i = 32'h1234; bus.link_addr_i = 32'hBAD0;
        exp_q.push_back('{adr: 5'd5, data: 32'h1234});
        tick();
        clear_inputs();
        tests_run++; if (bus.rf_we_o !== 1'b1) begin failed++; $display("FAIL alu_we: got %b, required 1", bus.rf_we_o); end
        tests_run++; if (bus.rfd_adr_o !== 5'd5) begin failed++; $display("FAIL alu_adr: got %0d, required 5", bus.rfd_adr_o); end
        tick();
        tests_run++; if (bus.rf_we_o !== 1'b0) begin failed++; $display("FAIL alu_pulse_end: got %b, required 0", bus.rf_we_o); end
        tests_run++; if (bus.result_o !== 32'h1234) begin failed++; $display("FAIL alu_result_hold: got %h, required 1234", bus.result_o); end
    endtask

    task automatic test_jal();
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.op_jal_i = 1'b1;
        bus.rfd_adr_i = 5'd9; bus.link_addr_i = 32'h108; bus.alu_result_i = 32'h0BAD;
        exp_q.push_back('{adr: 5'd9, data: 32'h108});
        tick();
        clear_inputs();
        tests_run++; if (bus.result_o !== 32'h108) begin failed++; $display("FAIL jal_result: got %h, required 108", bus.result_o); end
        tick();
    endtask

    task automatic test_load_delayed();
        int w0 = n_writes;
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.op_load_i = 1'b1; bus.rfd_adr_i = 5'd3;
        #1;
        tests_run++; if (bus.wb_stall_o !== 1'b1) begin failed++; $display("FAIL load_stall_launch: got %b, required 1", bus.wb_stall_o); end
        tick();
        clear_inputs();
        tests_run++; if (bus.wb_busy_o !== 1'b1) begin failed++; $display("FAIL load_busy: got %b, required 1", bus.wb_busy_o); end
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (bus.wb_stall_o !== 1'b1) begin failed++; $display("FAIL load_stall_wait%0d: got %b, required 1", i, bus.wb_stall_o); end
            tick();
        end
        bus.lsu_valid_i = 1'b1; bus.lsu_result_i = 32'hDEADBEEF;
        exp_q.push_back('{adr: 5'd3, data: 32'hDEADBEEF});
        #1;
        tests_run++; if (bus.wb_stall_o !== 1'b0) begin failed++; $display("FAIL load_stall_ack: got %b, required 0", bus.wb_stall_o); end
        tick();
        clear_inputs();
        tests_run++; if (bus.rf_we_o !== 1'b1) begin failed++; $display("FAIL load_we: got %b, required 1", bus.rf_we_o); end
        tests_run++; if (bus.wb_busy_o !== 1'b0) begin failed++; $display("FAIL load_idle: got %b, required 0", bus.wb_busy_o); end
        tick();
        tick();
        tests_run++; if (n_writes !== w0 + 1) begin failed++; $display("FAIL load_write_count: got %0d, required %0d", n_writes - w0, 1); end
    endtask

    task automatic test_load_except_and_flush();
        int w0 = n_writes;
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.op_load_i = 1'b1; bus.rfd_adr_i = 5'd7;
        tick();
        clear_inputs();
        tick();
        bus.lsu_valid_i = 1'b1; bus.lsu_except_i = 1'b1; bus.lsu_result_i = 32'h1111;
        tick();
        clear_inputs();
        tests_run++; if (bus.wb_busy_o !== 1'b0) begin failed++; $display("FAIL except_idle: got %b, required 0", bus.wb_busy_o); end
        // mfspr aborted by a flush in its acknowledge cycle.
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.op_mfspr_i = 1'b1; bus.rfd_adr_i = 5'd4;
        tick();
        clear_inputs();
        tests_run++; if (bus.wb_busy_o !== 1'b1) begin failed++; $display("FAIL spr_busy: got %b, required 1", bus.wb_busy_o); end
        bus.spr_ack_i = 1'b1; bus.spr_result_i = 32'h2222; bus.pipeline_flush_i = 1'b1;
        tick();
        clear_inputs();
        tests_run++; if (bus.wb_busy_o !== 1'b0) begin failed++; $display("FAIL flush_idle: got %b, required 0", bus.wb_busy_o); end
        tick();
        tests_run++; if (n_writes !== w0) begin failed++; $display("FAIL except_flush_writes: got %0d, required 0", n_writes - w0); end
    endtask

    task automatic test_r0_suppress();
        int w0 = n_writes;
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.rfd_adr_i = 5'd0; bus.alu_result_i = 32'hFFFF;
        tick();
        bus.rfd_adr_i = 5'd1; bus.alu_result_i = 32'h55;
        exp_q.push_back('{adr: 5'd1, data: 32'h55});
        tests_run++; if (bus.rf_we_o !== 1'b0) begin failed++; $display("FAIL r0_we: got %b, required 0", bus.rf_we_o); end
        tests_run++; if (bus.result_o !== 32'hFFFF) begin failed++; $display("FAIL r0_result: got %h, required ffff", bus.result_o); end
        tick();
        clear_inputs();
        tests_run++; if (bus.rfd_adr_o !== 5'd1) begin failed++; $display("FAIL r1_adr: got %0d, required 1", bus.rfd_adr_o); end
        tick();
        tests_run++; if (n_writes !== w0 + 1) begin failed++; $display("FAIL r0_write_count: got %0d, required 1", n_writes - w0); end
    endtask

    task automatic test_back_to_back();
        int w0 = n_writes;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d = $urandom;
            bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1;
            bus.rfd_adr_i = 5'(10 + i); bus.alu_result_i = d;
            exp_q.push_back('{adr: 5'(10 + i), data: d});
            tick();
        end
        clear_inputs();
        tick();
        tests_run++; if (n_writes !== w0 + 4) begin failed++; $display("FAIL b2b_write_count: got %0d, required 4", n_writes - w0); end
    endtask

    task automatic test_immediate_and_spr();
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.op_load_i = 1'b1; bus.rfd_adr_i = 5'd6;
        bus.lsu_valid_i = 1'b1; bus.lsu_result_i = 32'hA5A5_0006;
        exp_q.push_back('{adr: 5'd6, data: 32'hA5A5_0006});
        #1;
        tests_run++; if (bus.wb_stall_o !== 1'b0) begin failed++; $display("FAIL imm_stall: got %b, required 0", bus.wb_stall_o); end
        tick();
        clear_inputs();
        tests_run++; if (bus.wb_busy_o !== 1'b0) begin failed++; $display("FAIL imm_busy: got %b, required 0", bus.wb_busy_o); end
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.op_mfspr_i = 1'b1; bus.rfd_adr_i = 5'd8;
        tick();
        clear_inputs();
        tick();
        bus.spr_ack_i = 1'b1; bus.spr_result_i = 32'hCAFE_0001;
        exp_q.push_back('{adr: 5'd8, data: 32'hCAFE_0001});
        tick();
        clear_inputs();
        tests_run++; if (bus.rf_we_o !== 1'b1) begin failed++; $display("FAIL spr_we: got %b, required 1", bus.rf_we_o); end
        tick();
    endtask

    task automatic test_flush_idle_and_stray_ack();
        int w0 = n_writes;
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.rfd_adr_i = 5'd12;
        bus.alu_result_i = 32'h7777; bus.pipeline_flush_i = 1'b1;
        tick();
        clear_inputs();
        bus.lsu_valid_i = 1'b1; bus.spr_ack_i = 1'b1; bus.lsu_result_i = 32'h9999;
        tick();
        clear_inputs();
        tests_run++; if (bus.wb_busy_o !== 1'b0) begin failed++; $display("FAIL stray_busy: got %b, required 0", bus.wb_busy_o); end
        tick();
        tests_run++; if (n_writes !== w0) begin failed++; $display("FAIL flush_stray_writes: got %0d, required 0", n_writes - w0); end
    endtask

    task automatic test_reset_mid_wait();
        int w0 = n_writes;
        bus.insn_valid_i = 1'b1; bus.rf_wb_i = 1'b1; bus.op_load_i = 1'b1; bus.rfd_adr_i = 5'd2;
        tick();
        clear_inputs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.lsu_valid_i = 1'b1; bus.lsu_result_i = 32'h77;
        tick();
        clear_inputs();
        tests_run++; if (bus.rfd_adr_o !== 5'd0) begin failed++; $display("FAIL rstwait_adr: got %0d, required 0", bus.rfd_adr_o); end
        tests_run++; if (bus.result_o !== 32'd0) begin failed++; $display("FAIL rstwait_result: got %h, required 0", bus.result_o); end
        tests_run++; if (bus.wb_busy_o !== 1'b0) begin failed++; $display("FAIL rstwait_busy: got %b, required 0", bus.wb_busy_o); end
        tests_run++; if (bus.wb_stall_o !== 1'b0) begin failed++; $display("FAIL rstwait_stall: got %b, required 0", bus.wb_stall_o); end
        tick();
        tests_run++; if (n_writes !== w0) begin failed++; $display("FAIL rstwait_writes: got %0d, required 0", n_writes - w0); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu();
        test_jal();
        test_load_delayed();
        test_load_except_and_flush();
        test_r0_suppress();
        test_back_to_back();
        test_immediate_and_spr();
        test_flush_idle_and_stray_ack();
        test_reset_mid_wait();
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
